// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte-addressed load/store front end for a word-addressed memory with 1-cycle read latency
module lsu_mem_ctrl #(
    parameter int DEPTH = 2048,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_en,
    output logic            mem_r_w,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_in,
    input  logic [XLEN-1:0] mem_out
);
    typedef enum logic [2:0] {IDLE, RD, LDCAP, WR, RMW_RD, RMW_MRG, RMW_WR, ERR} state_t;

    state_t          state, state_nx;
    logic            we_q, uns_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, merged_q;
    logic            accept, bad, done;
    logic [7:0]      byte_l;
    logic [15:0]     half_l;
    logic [XLEN-1:0] ext, merged;

    assign req_ready = state == IDLE;
    assign accept    = req_valid & req_ready;
    assign done      = state inside {LDCAP, WR, RMW_WR, ERR};
    assign bad       = (req_size == 2'd3) | (req_size == 2'd1 & req_addr[0]) |
                       (req_size == 2'd2 & req_addr[1:0] != 2'd0) |
                       (req_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH));

    assign byte_l = mem_out[{addr_q[1:0], 3'b000} +: 8];
    assign half_l = addr_q[1] ? mem_out[31:16] : mem_out[15:0];
    assign ext    = size_q == 2'd0 ? {{(XLEN-8){~uns_q & byte_l[7]}}, byte_l} :
                    size_q == 2'd1 ? {{(XLEN-16){~uns_q & half_l[15]}}, half_l} : mem_out;

    // Memory port is gated by rst_n so a reset mid-sequence never reaches the array
    assign mem_en      = rst_n & (state inside {RD, WR, RMW_RD, RMW_WR});
    assign mem_r_w     = mem_en & (state inside {WR, RMW_WR});
    assign mem_address = mem_en ? {2'b00, addr_q[XLEN-1:2]} : '0;
    assign mem_in      = !(mem_en & mem_r_w) ? '0 : state == WR ? wdata_q : merged_q;

    // Replace the addressed lane of the read word with the store data
    always_comb begin
        merged = mem_out;
        if (size_q == 2'd0)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Next-state: errors skip memory entirely, sub-word stores go through read-modify-write
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = !accept ? IDLE : bad ? ERR : !req_we ? RD :
                                req_size == 2'd2 ? WR : RMW_RD;
            RD:      state_nx = LDCAP;
            RMW_RD:  state_nx = RMW_MRG;
            RMW_MRG: state_nx = RMW_WR;
            default: state_nx = IDLE;
        endcase
    end

    // State, request capture, merge register and registered response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            resp_valid <= done;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RMW_MRG)
                merged_q <= merged;
            if (done) begin
                resp_rdata <= state == LDCAP ? ext : '0;
                resp_err   <= state == ERR;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a behavioural 1-cycle-latency memory
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_en, mem_r_w;
    logic [31:0] resp_rdata, mem_address, mem_in;
    logic [31:0] mem_out = '0;
    logic [31:0] mem [0:2047];

    typedef struct { logic [31:0] d; logic e; int c; } exp_t;
    exp_t q[$];
    exp_t ex;
    int   cyc = 0, en_cnt = 0, n_cmp = 0, n_bad = 0;
    int   a1, a2, en0;

    lsu_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
        .mem_r_w(mem_r_w), .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_r_w) mem[mem_address[10:0]] <= mem_in;
            else mem_out <= mem[mem_address[10:0]];
        end
    end

    always @(negedge clk) begin
        if (mem_en) en_cnt++;
        if (!mem_en && (mem_address != 0 || mem_in != 0)) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_port: address=%h in=%h, required 0 while mem_en=0", mem_address, mem_in);
        end
        if (rst_n && resp_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: rdata=%h err=%b cyc=%0d, no response expected", resp_rdata, resp_err, cyc);
            end else begin
                ex = q.pop_front();
                if (resp_rdata !== ex.d || resp_err !== ex.e || cyc != ex.c) begin
                    n_bad++;
                    $display("FAIL resp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             resp_rdata, resp_err, cyc, ex.d, ex.e, ex.c);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                         input int lat, output int acc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: addr=%h not accepted in 50 cycles", a);
        end
        acc = cyc;
        q.push_back('{exp_d, exp_e, cyc + lat});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        issue(1, 2, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, a1);
        drain();
        chk("sw_mem4", mem[4], 32'h11223344);
        issue(0, 2, 0, 32'h10, 32'h0, 32'h11223344, 0, 3, a1);
        issue(1, 0, 0, 32'h13, 32'hAB, 32'h0, 0, 4, a1);
        drain();
        chk("sb_mem4", mem[4], 32'hAB223344);
        issue(0, 0, 0, 32'h13, 32'h0, 32'hFFFFFFAB, 0, 3, a1);
        issue(0, 0, 1, 32'h13, 32'h0, 32'h000000AB, 0, 3, a1);
        issue(0, 1, 0, 32'h12, 32'h0, 32'hFFFFAB22, 0, 3, a1);
        issue(0, 0, 0, 32'h10, 32'h0, 32'h00000044, 0, 3, a1);
        issue(1, 1, 0, 32'h16, 32'hFFFF5566, 32'h0, 0, 4, a1);
        issue(0, 1, 1, 32'h16, 32'h0, 32'h00005566, 0, 3, a1);
        drain();
        chk("sh_mem5", mem[5], 32'h55660000);

        en0 = en_cnt;
        issue(0, 1, 0, 32'h11, 32'h0, 32'h0, 1, 2, a1);
        issue(0, 2, 0, 32'h2000, 32'h0, 32'h0, 1, 2, a1);
        issue(1, 3, 0, 32'h20, 32'h12345678, 32'h0, 1, 2, a1);
        issue(1, 2, 0, 32'h1FFC, 32'h12345678, 32'h0, 0, 2, a1);
        drain();
        chk("err_no_access", en_cnt - en0, 32'd1);
        chk("last_word_mem", mem[2047], 32'h12345678);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h11; req_wdata = 32'hCD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("rmw_wr_en", {31'b0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_mid_mem_en", {31'b0, mem_en}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mid_rdata", resp_rdata, 32'd0);
        chk("rst_mid_mem4", mem[4], 32'hAB223344);

        issue(0, 2, 0, 32'h10, 32'h0, 32'hAB223344, 0, 3, a1);
        issue(1, 2, 0, 32'h14, 32'hDEADBEEF, 32'h0, 0, 2, a2);
        drain();
        chk("b2b_accept", a2 - a1, 32'd3);
        chk("b2b_mem5", mem[5], 32'hDEADBEEF);
        issue(0, 2, 0, 32'h14, 32'h0, 32'hDEADBEEF, 0, 3, a1);
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
